// File: rtl/cache_pkg.sv
// cache_pkg: shared defaults and state encoding for the offset scanner.
package cache_pkg;
  localparam int MASK_W_DEF = 32;
  localparam int OFF_W_DEF  = 5;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_e;
endpackage

// File: rtl/prio_enc32.sv
// prio_enc32: combinational lowest-set-bit encoder (index plus any-set flag).
module prio_enc32
  import cache_pkg::*;
#(
  parameter int W  = MASK_W_DEF,
  parameter int IW = OFF_W_DEF
) (
  input  logic [W-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--)
      if (mask[i]) idx = IW'(i);
  end
  assign any = |mask;
endmodule

// File: rtl/offset_scanner.sv
// offset_scanner: converts a word mask into a stream of set-bit offsets, LSB first.
// Define OFFSET_SCANNER_ONEHOT_EN to add the one-hot word_en output.
module offset_scanner
  import cache_pkg::*;
#(
  parameter int MASK_W = MASK_W_DEF,
  parameter int OFF_W  = OFF_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MASK_W-1:0] mask_in,
  input  logic              abort,
  input  logic              out_ready,
`ifdef OFFSET_SCANNER_ONEHOT_EN
  output logic [MASK_W-1:0] word_en,
`endif
  output logic              start_ready,
  output logic [OFF_W-1:0]  offset,
  output logic              out_valid,
  output logic              done,
  output logic              busy
);
  scan_state_e       state_q, state_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic [OFF_W-1:0]  nxt_idx;
  logic              nxt_any;
  logic              load, xfer;
  assign load = state_q == IDLE && start;
  assign xfer = state_q == SCAN && out_valid_q && out_ready;
  // Clearing the lowest set bit is exactly the bit currently presented on offset.
  always_comb begin
    mask_d = abort ? '0 : load ? mask_in : xfer ? mask_q & (mask_q - MASK_W'(1)) : mask_q;
  end
  prio_enc32 #(.W(MASK_W), .IW(OFF_W)) u_enc (
    .mask (mask_d),
    .idx  (nxt_idx),
    .any  (nxt_any)
  );
  // Outputs are computed from the next mask so they are registered yet still show latency 1.
  always_comb begin
    state_d = abort ? IDLE
            : load ? (nxt_any ? SCAN : DONE)
            : state_q == SCAN ? (nxt_any ? SCAN : DONE)
            : IDLE;
    out_valid_d = state_d == SCAN;
    offset_d    = state_d == SCAN ? nxt_idx : '0;
    done_d      = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      offset_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      offset_q    <= offset_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end
  assign start_ready = state_q == IDLE;
  assign busy        = state_q == SCAN || state_q == DONE;
  assign offset      = offset_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;
`ifdef OFFSET_SCANNER_ONEHOT_EN
  assign word_en = out_valid_q ? MASK_W'(1) << offset_q : '0;
`endif
endmodule

// File: doc/offset_scanner.md
OFFSET_SCANNER -- requirements
Module: offset_scanner

Interface
REQ-001 Parameter MASK_W, default 32, is the word-mask width (one bit per cache-block word).
REQ-002 Parameter OFF_W, default 5, is the offset width; it SHALL equal clog2(MASK_W).
REQ-003 clk  input  1  is the single clock; all state is on its rising edge.
REQ-004 rst_n  input  1  is the reset, asynchronous and active-low.
REQ-005 start  input  1  requests a load of mask_in (qualified by start_ready).
REQ-006 mask_in  input  MASK_W  is a word mask (dirty/valid bits) to be converted to offsets.
REQ-007 start_ready  output  1  is high only in IDLE.
REQ-008 abort  input  1  is a synchronous cancel of any scan in progress.
REQ-009 offset  output  OFF_W  is the index of the lowest set bit in the working mask.
REQ-010 out_valid  output  1  means offset is valid.
REQ-011 out_ready  input  1  is the consumer's acceptance of offset.
REQ-012 done  output  1  is a one-cycle pulse at the end of a scan.
REQ-013 busy  output  1  is high in SCAN or DONE.

Function
REQ-014 States SHALL be IDLE, SCAN and DONE.
REQ-015 IDLE + start=1 + abort=0 SHALL register mask_in into the working mask and go to SCAN if mask_in!=0, else go to DONE.
REQ-016 First out_valid SHALL assert the cycle after start is accepted (latency 1).
REQ-017 In SCAN, out_valid=1 and offset = index of the lowest set working-mask bit (LSB priority, bit 0 -> 0, bit MASK_W-1 -> MASK_W-1).
REQ-018 offset and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 Transfer on out_valid&out_ready SHALL clear that bit; if it was the last set bit, the next state is DONE, else SCAN.
REQ-020 Throughput SHALL be one offset per cycle with out_ready held high.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 start in SCAN or DONE SHALL be ignored (no queueing).
REQ-023 abort=1 in any state SHALL clear the working mask and go to IDLE next cycle with no done pulse; abort wins over simultaneous start or transfer.
REQ-024 Outside SCAN, out_valid=0 and offset=0.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, working mask=0, offset=0, out_valid=0, done=0, busy=0 and start_ready=1.
REQ-026 Reset mid-scan SHALL discard remaining bits with no done pulse.

Configuration
REQ-027 With OFFSET_SCANNER_ONEHOT_EN defined, output word_en (MASK_W) SHALL equal the one-hot of offset when out_valid=1 and 0 otherwise. Without the macro, the port SHALL be absent.

Structure
REQ-028 MASK_W/OFF_W defaults and the state enum typedef SHALL live in shared package cache_pkg.
REQ-029 The lowest-set-bit encode SHALL be a combinational sub-module prio_enc32 (mask in -> index plus any-set flag).

Verification
REQ-030 A bench SHALL cover the following directed scenarios:
- start with mask 0x8000_0011, out_ready=1 -> offsets 0, 4, 31 on consecutive cycles, then done pulse, then start_ready=1.
- start with mask 0 -> DONE next cycle, done pulse, no out_valid.
- mask 0x0000_0006, out_ready low 3 cycles -> offset holds 1 with out_valid=1, then 1, 2 are accepted.
- abort during SCAN after the first transfer of 0xF -> IDLE next cycle, no done, remaining bits dropped.
- start during SCAN with a different mask -> ignored; original sequence completes.
- rst_n low mid-scan -> all outputs at reset values asynchronously; with the macro defined, word_en=0.
